// File: rtl/tcp_tx_seg_sched.sv
// Transmit segment scheduler: tracks per-flow send/lead pointers, round-robins
// among flows with unsent payload and issues one segment command per handshake.
module tcp_tx_seg_sched #(
  parameter int PTR_W         = 15,
  parameter int FLOWID_W      = 3,
  parameter int MAX_SEG_BYTES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                app_sched_lead_upd_val,
  input  logic [FLOWID_W-1:0] app_sched_lead_upd_flowid,
  input  logic [PTR_W:0]      app_sched_lead_upd_ptr,
  input  logic                init_sched_val,
  input  logic [FLOWID_W-1:0] init_sched_flowid,
  input  logic [PTR_W:0]      init_sched_ptr,
  output logic                sched_init_rdy,
  output logic                sched_tx_seg_val,
  output logic [FLOWID_W-1:0] sched_tx_seg_flowid,
  output logic [PTR_W:0]      sched_tx_seg_start_ptr,
  output logic [PTR_W:0]      sched_tx_seg_len,
  input  logic                tx_sched_seg_rdy
);

  localparam int NUM_FLOWS = 1 << FLOWID_W;
  localparam int PW        = PTR_W + 1;
  localparam logic [PTR_W:0] MAX_LEN = PW'(MAX_SEG_BYTES);
  localparam logic [PTR_W:0] MIN_BLK = PW'(32);

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t                state_q, state_d;
  logic [FLOWID_W-1:0]   cur_q, cur_d;
  logic [FLOWID_W-1:0]   last_grant_q, last_grant_d;
  logic [FLOWID_W-1:0]   cmd_flow_q, cmd_flow_d;
  logic [PTR_W:0]        cmd_start_q, cmd_start_d;
  logic [PTR_W:0]        cmd_len_q, cmd_len_d;
  logic [PTR_W:0]        send_q [NUM_FLOWS];
  logic [PTR_W:0]        lead_q [NUM_FLOWS];

  logic [NUM_FLOWS-1:0]  pending;
  logic                  grant_found;
  logic [FLOWID_W-1:0]   grant_flow;
  logic [FLOWID_W-1:0]   search_idx;
  logic [PTR_W:0]        calc_diff;
  logic [PTR_W:0]        calc_len;
  logic                  init_acc;
  logic                  advance;

  // Lengths of 32 bytes or more are rounded down to a 32-byte multiple.
  function automatic logic [PTR_W:0] seg_len(input logic [PTR_W:0] diff);
    if (diff > MAX_LEN)
      return MAX_LEN;
    else if (diff < MIN_BLK)
      return diff;
    else
      return {diff[PTR_W:5], 5'b0};
  endfunction

  always_comb begin
    pending = '0;
    for (int f = 0; f < NUM_FLOWS; f++)
      pending[f] = (lead_q[f] != send_q[f]);
  end

  // Round-robin search starting just after the last granted flow.
  always_comb begin
    grant_found = 1'b0;
    grant_flow  = last_grant_q;
    search_idx  = last_grant_q;
    for (int i = 1; i <= NUM_FLOWS; i++) begin
      search_idx = last_grant_q + i[FLOWID_W-1:0];
      if (!grant_found && pending[search_idx]) begin
        grant_found = 1'b1;
        grant_flow  = search_idx;
      end
    end
  end

  assign calc_diff = lead_q[cur_q] - send_q[cur_q];
  assign calc_len  = seg_len(calc_diff);
  assign init_acc  = init_sched_val && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    cmd_flow_d   = cmd_flow_q;
    cmd_start_d  = cmd_start_q;
    cmd_len_d    = cmd_len_q;
    advance      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cur_d        = grant_flow;
          last_grant_d = grant_flow;
          state_d      = CALC;
        end
      end
      CALC: begin
        if (calc_len == '0) begin
          state_d = IDLE;
        end else begin
          cmd_flow_d  = cur_q;
          cmd_start_d = send_q[cur_q];
          cmd_len_d   = calc_len;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (tx_sched_seg_rdy) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_grant_q <= FLOWID_W'(NUM_FLOWS - 1);
      cmd_flow_q   <= '0;
      cmd_start_q  <= '0;
      cmd_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      cmd_flow_q   <= cmd_flow_d;
      cmd_start_q  <= cmd_start_d;
      cmd_len_q    <= cmd_len_d;
    end
  end

  // Init is written last so it overrides a same-cycle lead update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        send_q[f] <= '0;
        lead_q[f] <= '0;
      end
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (advance && (cur_q == FLOWID_W'(f)))
          send_q[f] <= send_q[f] + cmd_len_q;
        if (app_sched_lead_upd_val && (app_sched_lead_upd_flowid == FLOWID_W'(f)))
          lead_q[f] <= app_sched_lead_upd_ptr;
        if (init_acc && (init_sched_flowid == FLOWID_W'(f))) begin
          send_q[f] <= init_sched_ptr;
          lead_q[f] <= init_sched_ptr;
        end
      end
    end
  end

  assign sched_init_rdy         = (state_q == IDLE);
  assign sched_tx_seg_val       = (state_q == SEND);
  assign sched_tx_seg_flowid    = cmd_flow_q;
  assign sched_tx_seg_start_ptr = cmd_start_q;
  assign sched_tx_seg_len       = cmd_len_q;

endmodule

// File: doc/tcp_tx_seg_sched.md
# tcp_tx_seg_sched

Transmit-side segment scheduler for the TCP slow path. It keeps per-flow send and lead pointers and round-robins among flows with unsent payload. For each selected flow it computes a segment length under the 32-byte-multiple / MAX_SEG_BYTES rule and issues one segment command per handshake to the TX packet builder. It sits between the app/flow-setup logic, which moves pointers, and the segment engine, which consumes commands.

## Interface
- PTR_W, 15: pointer MSB index; pointers are PTR_W+1 bits and wrap modulo 2^(PTR_W+1)
- FLOWID_W, 3: flow id width; NUM_FLOWS = 2^FLOWID_W
- MAX_SEG_BYTES, 1024: maximum segment length in bytes; must be a multiple of 32
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- app_sched_lead_upd_val  in  1  lead-pointer update strobe; always accepted
- app_sched_lead_upd_flowid  in  FLOWID_W  flow being updated
- app_sched_lead_upd_ptr  in  PTR_W+1  new lead pointer
- init_sched_val  in  1  flow init request
- init_sched_flowid  in  FLOWID_W  flow to init
- init_sched_ptr  in  PTR_W+1  initial value; written to both send and lead pointers
- sched_init_rdy  out  1  init accepted when val&rdy
- sched_tx_seg_val  out  1  segment command valid
- sched_tx_seg_flowid  out  FLOWID_W  flow of segment
- sched_tx_seg_start_ptr  out  PTR_W+1  first byte pointer of segment
- sched_tx_seg_len  out  PTR_W+1  segment length in bytes
- tx_sched_seg_rdy  in  1  consumer accepts command when val&rdy

## Operation
- Per-flow registers: send_ptr[f] and lead_ptr[f]. A flow is pending when lead_ptr[f] != send_ptr[f].
- Lead update: lead_ptr[flowid] <= upd_ptr on the cycle val is high, in any state.
- Init: sched_init_rdy = (state == IDLE). On accept, send_ptr and lead_ptr of that flow are both set to init_ptr, so the flow becomes non-pending.
- Init and lead update to the same flow in the same cycle: init wins for lead_ptr.
- FSM states:
  - IDLE: if any flow is pending, grant the first pending flow searching from last_grant+1 (mod NUM_FLOWS), register it in cur_flow, update last_grant, and go to CALC. Otherwise stay in IDLE.
  - CALC: diff = lead_ptr[cur] - send_ptr[cur], truncated to PTR_W+1 bits (wrap-safe).
    - len = MAX_SEG_BYTES if diff > MAX_SEG_BYTES.
    - Otherwise len = diff if diff < 32.
    - Otherwise len = diff with its low 5 bits cleared.
    - If len == 0, return to IDLE with no command (the lead was rewritten back to send).
    - Else register flowid, start_ptr = send_ptr[cur], and len, then go to SEND.
  - SEND: sched_tx_seg_val = 1, with all command fields held stable. On val&rdy, send_ptr[cur] <= send_ptr[cur] + len (wrapping) and go to IDLE.
- Lead updates to cur_flow during CALC/SEND do not alter a registered command. Remaining data is picked up on a later grant.
- Send-pointer advance and a lead update to the same flow in the same cycle both take effect.

## Timing
- Reset values:
  - All send_ptr/lead_ptr = 0, state = IDLE.
  - last_grant = NUM_FLOWS-1, so flow 0 is searched first.
  - sched_tx_seg_val = 0, and flowid/start_ptr/len = 0.
  - sched_init_rdy = 1 in the first post-reset cycle.
- Latency: flow pending in IDLE at cycle t gives sched_tx_seg_val high at t+2.
- Handshake at cycle h: val low at h+1 (IDLE). The next command is at h+3 at the earliest. Maximum rate is one segment per 3 cycles.
- val never drops before the handshake. rdy may be low indefinitely.
- Reset asserted in any state takes priority: next cycle is IDLE with all pointers 0, and any in-flight command is discarded.

## Test plan
- Init flow 2 with ptr 0, then lead update flow 2 to 100 → command {flow 2, start 0, len 96}, then {flow 2, start 96, len 4}, then no further val.
- Lead flow 0 set to 3000 → lens 1024, 1024, 928, 24 with starts 0, 1024, 2048, 2976.
- Wrap: init flow 1 at 0xFFF0, lead 0x0030 → {start 0xFFF0, len 64}, after which send_ptr = 0x0030 and the flow is idle.
- Round-robin: flows 1 and 3 pending with last_grant = 1 → flow 3 granted before flow 1. With only flow 5 pending, it is granted repeatedly until drained.
- Backpressure: hold rdy low 5 cycles in SEND → val and fields stable throughout, a single pointer advance after rdy rises, and sched_init_rdy low throughout.
- Lead rewritten to send_ptr during CALC → no command, return to IDLE. Reset asserted during SEND → val 0 next cycle, all pointers 0.
